soc_gpio_pio_irq: RTL and testbench
===================================

// Module: soc_gpio_pio_irq
// PURPOSE
//  Parametrised Avalon-MM GPIO port: per-bit direction, output set/clear,
//  synchronised inputs, edge capture with per-bit IRQ mask and one IRQ line.
//  Successor to the fixed-width PIO ports on the soc Avalon fabric; one
//  instance per board GPIO bank (sensors, relays, 7-seg).
// PARAMETERS
//  DATA_WIDTH   20  port width, 1..32; readdata bits above it read 0
//  SYNC_STAGES  2   input synchroniser depth, 2..4
//  EDGE_TYPE    0   0 rising, 1 falling, 2 any edge
//  RESET_OUT    0   data_out value after reset (DATA_WIDTH bits)
//  RESET_DIR    0   dir value after reset (1 = bit drives output)
// PORTS
//  clk         in   1           system clock
//  reset       in   1           synchronous, active-high reset
//  address     in   3           register index
//  chipselect  in   1           slave select
//  write_n     in   1           active-low write strobe
//  writedata   in   32          write data
//  readdata    out  32          registered read data
//  in_port     in   DATA_WIDTH  asynchronous pin inputs
//  out_port    out  DATA_WIDTH  data_out register
//  oe_port     out  DATA_WIDTH  dir register (per-bit output enable)
//  irq         out  1           level interrupt
// BEHAVIOUR
//  Registers (wr = chipselect & ~write_n, acts on clk edge):
//   0 DATA   wr: data_out<=wd; rd: dir?data_out:sync_in per bit
//   1 DIR    wr: dir<=wd; rd: dir
//   2 MASK   wr: irqmask<=wd; rd: irqmask
//   3 EDGE   wr: W1C edge_cap; rd: edge_cap
//   4 OUTSET wr: data_out<=data_out|wd; rd: 0
//   5 OUTCLR wr: data_out<=data_out&~wd; rd: 0
//   6,7      wr ignored; rd 0
//  - readdata: registered every clk from address (chipselect ignored);
//    1-cycle latency, zero-extended.
//  - in_port -> SYNC_STAGES flops -> sync_in; sync_prev <= sync_in.
//    Edge: rise = sync_in&~sync_prev, fall = ~sync_in&sync_prev.
//  - edge_cap[i] sets on the clk after the edge on sync_in; latency
//    in_port->edge_cap = SYNC_STAGES+1 clks. Edge on all bits incl. dir=1.
//  - Edge and W1C on same bit same cycle: set wins (edge not lost).
//  - irq = |(edge_cap & irqmask), combinational from registers, no glitch.
//  - Arm counter: after reset counts SYNC_STAGES+1 clks; edge detection
//    disabled until done (no false edge from pins already high).
//  - Reset (sync, any cycle incl. mid-write): readdata 0, data_out
//    RESET_OUT, dir RESET_DIR, irqmask 0, edge_cap 0, sync flops 0,
//    arm counter restarted; irq 0 next cycle. Reset dominates writes.
//  - writedata bits >= DATA_WIDTH ignored.
// TESTING
//  1 Reset, read all 8 addrs -> DIR=RESET_DIR, others 0, irq=0; in_port
//    held 0xFFFFF across reset -> EDGE stays 0.
//  2 wr DATA 0x0000F, OUTSET 0x000F0, OUTCLR 0x00003 -> out_port 0x000FC;
//    readdata valid 1 clk after address.
//  3 EDGE_TYPE=0, MASK=0x1; in_port[0] 0->1 -> edge_cap[0] and irq high
//    exactly 3 clks later (SYNC_STAGES=2); 1->0 -> no new capture.
//  4 Edge on bit 0 same clk as W1C 0x1 to EDGE -> edge_cap[0] stays 1;
//    W1C next clk alone -> 0, irq drops.
//  5 DIR=0x00F, DATA=0x005, in_port=0xFFFFF -> read DATA = 0xFFFF5.
//  6 DATA_WIDTH=8: write 0xFFFFFFFF to DATA -> out_port 0xFF, readdata
//    upper 24 bits 0; reset asserted during write -> data_out RESET_OUT.

Source files
------------

// File: rtl/soc_gpio_pio_irq.sv
// soc_gpio_pio_irq: Avalon-MM GPIO bank with per-bit direction, set/clear output
// updates, input synchronisation, edge capture and a single masked level interrupt.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   address     register index (0 DATA, 1 DIR, 2 MASK, 3 EDGE, 4 OUTSET, 5 OUTCLR)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data; bits at and above DATA_WIDTH are ignored
//   readdata    registered read data, one cycle after address, zero-extended
//   in_port     asynchronous pin inputs
//   out_port    data_out register
//   oe_port     dir register (1 = bit drives the pin)
//   irq         level interrupt, |(edge_cap & irqmask)
module soc_gpio_pio_irq #(
  parameter int unsigned            DATA_WIDTH  = 20,
  parameter int unsigned            SYNC_STAGES = 2,
  parameter int unsigned            EDGE_TYPE   = 0,
  parameter logic [DATA_WIDTH-1:0]  RESET_OUT   = '0,
  parameter logic [DATA_WIDTH-1:0]  RESET_DIR   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe_port,
  output logic                  irq
);

  localparam logic [2:0] AddrData   = 3'd0;
  localparam logic [2:0] AddrDir    = 3'd1;
  localparam logic [2:0] AddrMask   = 3'd2;
  localparam logic [2:0] AddrEdge   = 3'd3;
  localparam logic [2:0] AddrOutSet = 3'd4;
  localparam logic [2:0] AddrOutClr = 3'd5;

  // Edge detection stays off until the synchroniser and sync_prev hold real
  // pin values, so pins already high at reset do not look like rising edges.
  localparam logic [2:0] ArmCnt = 3'(SYNC_STAGES + 1);

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t       data_out_q, data_out_d;
  word_t       dir_q,      dir_d;
  word_t       irqmask_q,  irqmask_d;
  word_t       edge_cap_q, edge_cap_d;
  word_t       sync_prev_q;
  word_t       sync_q [SYNC_STAGES];
  word_t       sync_d [SYNC_STAGES];
  logic [2:0]  arm_cnt_q,  arm_cnt_d;
  logic [31:0] readdata_q, readdata_d;

  word_t wd;
  word_t sync_in;
  word_t rise;
  word_t fall;
  word_t edge_det;
  word_t w1c;
  word_t rd_val;
  logic  wr_en;
  logic  armed;
  logic  unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wd        = writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign sync_in   = sync_q[SYNC_STAGES-1];
  assign armed     = (arm_cnt_q == ArmCnt);

  // Input synchroniser chain.
  always_comb begin
    sync_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 3'd1;
  end

  // Edge detection on every bit regardless of direction.
  always_comb begin
    rise     = sync_in & ~sync_prev_q;
    fall     = ~sync_in & sync_prev_q;
    edge_det = '0;
    if (armed) begin
      case (EDGE_TYPE)
        0:       edge_det = rise;
        1:       edge_det = fall;
        default: edge_det = rise | fall;
      endcase
    end
  end

  // Register writes.
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irqmask_d  = irqmask_q;
    w1c        = '0;
    if (wr_en) begin
      case (address)
        AddrData:   data_out_d = wd;
        AddrDir:    dir_d      = wd;
        AddrMask:   irqmask_d  = wd;
        AddrEdge:   w1c        = wd;
        AddrOutSet: data_out_d = data_out_q | wd;
        AddrOutClr: data_out_d = data_out_q & ~wd;
        default:    ;
      endcase
    end
    // A new edge wins over a simultaneous clear so it is never lost.
    edge_cap_d = (edge_cap_q & ~w1c) | edge_det;
  end

  // Read mux; registered every cycle irrespective of chipselect.
  always_comb begin
    rd_val = '0;
    case (address)
      AddrData: rd_val = (dir_q & data_out_q) | (~dir_q & sync_in);
      AddrDir:  rd_val = dir_q;
      AddrMask: rd_val = irqmask_q;
      AddrEdge: rd_val = edge_cap_q;
      default:  rd_val = '0;
    endcase
    readdata_d = 32'(rd_val);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q  <= RESET_OUT;
      dir_q       <= RESET_DIR;
      irqmask_q   <= '0;
      edge_cap_q  <= '0;
      sync_prev_q <= '0;
      arm_cnt_q   <= '0;
      readdata_q  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      data_out_q  <= data_out_d;
      dir_q       <= dir_d;
      irqmask_q   <= irqmask_d;
      edge_cap_q  <= edge_cap_d;
      sync_prev_q <= sync_in;
      arm_cnt_q   <= arm_cnt_d;
      readdata_q  <= readdata_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign readdata = readdata_q;
  assign out_port = data_out_q;
  assign oe_port  = dir_q;
  assign irq      = |(edge_cap_q & irqmask_q);

endmodule

// File: tb/tb_soc_gpio_pio_irq.sv
// Testbench for soc_gpio_pio_irq: a 20-bit instance with default parameters and an
// 8-bit instance (RESET_OUT 0x5A, RESET_DIR 0x0F) share the bus; the 8-bit one has
// its own reset. Expected values are queued by the driver and checked by a monitor.
module tb_soc_gpio_pio_irq;

  logic        clk = 1'b0;
  logic        reset;
  logic        reset8;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [19:0] in_port;
  logic [31:0] readdata;
  logic [19:0] out_port;
  logic [19:0] oe_port;
  logic        irq;
  logic [31:0] readdata8;
  logic [7:0]  out_port8;
  logic [7:0]  oe_port8;
  logic        irq8;

  soc_gpio_pio_irq #(
    .DATA_WIDTH  (20),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (0),
    .RESET_OUT   (20'h00000),
    .RESET_DIR   (20'h00000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .oe_port    (oe_port),
    .irq        (irq)
  );

  soc_gpio_pio_irq #(
    .DATA_WIDTH  (8),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (0),
    .RESET_OUT   (8'h5A),
    .RESET_DIR   (8'h0F)
  ) dut8 (
    .clk        (clk),
    .reset      (reset8),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata8),
    .in_port    (in_port[7:0]),
    .out_port   (out_port8),
    .oe_port    (oe_port8),
    .irq        (irq8)
  );

  always #5 clk = ~clk;

  // Observation selectors.
  localparam int SelRd   = 0;
  localparam int SelOut  = 1;
  localparam int SelOe   = 2;
  localparam int SelIrq  = 3;
  localparam int SelRd8  = 4;
  localparam int SelOut8 = 5;
  localparam int SelOe8  = 6;
  localparam int SelIrq8 = 7;

  int          checks = 0;
  int          errors = 0;
  logic        rq = 1'b0;
  int          sel_q[$];
  logic [31:0] exp_q[$];
  string       name_q[$];

  int          m_sel;
  logic [31:0] m_exp;
  logic [31:0] m_act;
  string       m_name;

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      SelRd:   return readdata;
      SelOut:  return {12'h000, out_port};
      SelOe:   return {12'h000, oe_port};
      SelIrq:  return {31'h0, irq};
      SelRd8:  return readdata8;
      SelOut8: return {24'h0, out_port8};
      SelOe8:  return {24'h0, oe_port8};
      default: return {31'h0, irq8};
    endcase
  endfunction

  // Monitor: a request flagged in a cycle is checked just after that cycle's edge.
  always @(posedge clk) begin
    if (rq) begin
      #1;
      if (sel_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: request with empty expectation queue");
      end else begin
        m_sel  = sel_q.pop_front();
        m_exp  = exp_q.pop_front();
        m_name = name_q.pop_front();
        m_act  = pick(m_sel);
        checks++;
        if (m_act !== m_exp) begin
          errors++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", m_name, m_act, m_exp);
        end
      end
    end
  end

  task automatic push(input int sel, input logic [31:0] exp, input string nm);
    sel_q.push_back(sel);
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  // All tasks start and end at a falling edge and span one clock.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input int sel, input logic [2:0] a, input logic [31:0] exp,
                    input string nm);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    push(sel, exp, nm);
    rq = 1'b1;
    @(negedge clk);
    rq = 1'b0; chipselect = 1'b0;
  endtask

  task automatic obs(input int sel, input logic [31:0] exp, input string nm);
    push(sel, exp, nm);
    rq = 1'b1;
    @(negedge clk);
    rq = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; reset8 = 1'b1;
    address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    in_port = 20'hFFFFF;
    idle(3);
    reset = 1'b0; reset8 = 1'b0;

    // Reset state; pins high across reset must not be captured as edges.
    rd(SelRd, 3'd0, 32'h0, "rst_data");
    rd(SelRd, 3'd1, 32'h0, "rst_dir");
    rd(SelRd, 3'd2, 32'h0, "rst_mask");
    rd(SelRd, 3'd3, 32'h0, "rst_edge");
    for (int a = 4; a < 8; a++) rd(SelRd, 3'(a), 32'h0, "rst_rd_hi");
    rd(SelRd, 3'd3, 32'h0, "rst_edge_late");
    obs(SelIrq, 32'h0, "rst_irq");
    obs(SelOut, 32'h0, "rst_out");
    obs(SelOe, 32'h0, "rst_oe");
    rd(SelRd8, 3'd1, 32'h0F, "rst_dir8");

    // Set/clear writes; falling pins are not captured with rising-edge mode.
    in_port = 20'h00000;
    wr(3'd0, 32'h0000F);
    wr(3'd4, 32'h000F0);
    wr(3'd5, 32'h00003);
    obs(SelOut, 32'h000FC, "outsetclr");
    wr(3'd1, 32'h000FF);
    rd(SelRd, 3'd0, 32'h000FC, "data_mix");
    rd(SelRd, 3'd1, 32'h000FF, "rd_latency");
    rd(SelRd, 3'd3, 32'h0, "no_fall_cap");

    // Rising edge on bit 0 raises edge_cap and irq exactly three clocks later.
    wr(3'd2, 32'h1);
    rd(SelRd, 3'd2, 32'h1, "mask_rd");
    in_port[0] = 1'b1;
    obs(SelIrq, 32'h0, "irq_lat1");
    obs(SelIrq, 32'h0, "irq_lat2");
    obs(SelIrq, 32'h1, "irq_lat3");
    rd(SelRd, 3'd3, 32'h1, "edge_cap0");
    wr(3'd3, 32'h1);
    rd(SelRd, 3'd3, 32'h0, "w1c_clear");
    obs(SelIrq, 32'h0, "irq_clear");
    in_port[0] = 1'b0;
    idle(4);
    rd(SelRd, 3'd3, 32'h0, "fall_no_cap");

    // Edge and W1C in the same cycle: the edge survives.
    in_port[0] = 1'b1;
    idle(2);
    wr(3'd3, 32'h1);
    rd(SelRd, 3'd3, 32'h1, "set_wins");
    obs(SelIrq, 32'h1, "set_wins_irq");
    wr(3'd3, 32'h1);
    rd(SelRd, 3'd3, 32'h0, "w1c_alone");
    obs(SelIrq, 32'h0, "irq_drop");

    // Mixed direction read-back and edges on output-enabled bits.
    wr(3'd1, 32'h0000F);
    wr(3'd0, 32'h00005);
    in_port = 20'hFFFFF;
    idle(3);
    rd(SelRd, 3'd0, 32'hFFFF5, "data_dir_mix");
    rd(SelRd, 3'd3, 32'hFFFFE, "edge_all_bits");
    obs(SelIrq, 32'h0, "irq_masked");
    obs(SelOe, 32'h0000F, "oe_port");
    obs(SelOut, 32'h00005, "out_port");
    wr(3'd2, 32'h00010);
    obs(SelIrq, 32'h1, "irq_mask_bit4");
    wr(3'd1, 32'hFFF0000F);
    rd(SelRd, 3'd1, 32'h0000F, "wd_upper_ignored");

    // Narrow instance: truncated writes, zero-extended reads, reset over a write.
    reset8 = 1'b1;
    idle(2);
    reset8 = 1'b0;
    wr(3'd0, 32'hFFFFFFFF);
    obs(SelOut8, 32'hFF, "w8_out");
    rd(SelRd8, 3'd0, 32'h000000FF, "w8_rd_zext");
    reset8 = 1'b1;
    wr(3'd0, 32'h00000033);
    obs(SelOut8, 32'h5A, "w8_rst_wins");
    obs(SelRd8, 32'h0, "w8_rst_rd");
    obs(SelIrq8, 32'h0, "w8_rst_irq");
    reset8 = 1'b0;
    rd(SelRd8, 3'd1, 32'h0F, "w8_dir");
    obs(SelOe8, 32'h0F, "w8_oe");

    idle(2);
    if (sel_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d pending, expected 0", sel_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
